// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared constants and helpers for the sequential multiplier
package mult_pkg;

  localparam int DEFAULT_WIDTH = 5;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ripple_adder.sv
// rtl/ripple_adder.sv - combinational N-bit ripple-carry adder, carry-out dropped
module ripple_adder #(
  parameter int N = 10
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  output logic [N-1:0] s
);

  // w_c[i] is the carry into bit i; the carry out of the top bit is never formed
  logic [N-1:0] w_c;

  assign w_c[0] = 1'b0;

  for (genvar i = 0; i < N; i++) begin : g_fa
    assign s[i] = x[i] ^ y[i] ^ w_c[i];
    if (i < N - 1) begin : g_carry
      assign w_c[i+1] = (x[i] & y[i]) | (w_c[i] & (x[i] ^ y[i]));
    end
  end

endmodule

// File: rtl/mult_seq_ctrl.sv
// rtl/mult_seq_ctrl.sv - shift-and-add multiplier sharing one ripple adder over WIDTH cycles
module mult_seq_ctrl
  import mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 CLOCK_50,
  input  logic                 RESET_N,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int              PW   = 2 * WIDTH;
  localparam int              CW   = clog2(WIDTH) + 1;
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [PW-1:0]    r_acc;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [PW-1:0]    r_product;

  logic             w_bit;
  logic [PW-1:0]    w_a_ext;
  logic [PW-1:0]    w_addend;
  logic [PW-1:0]    w_sum;

  // Current multiplier bit selects whether the shifted multiplicand is added
  assign w_bit    = |(r_b & (WIDTH'(1) << r_cnt));
  assign w_a_ext  = {{WIDTH{1'b0}}, r_a};
  assign w_addend = w_bit ? (w_a_ext << r_cnt) : '0;

  ripple_adder #(.N(PW)) u_adder (
    .x (r_acc),
    .y (w_addend),
    .s (w_sum)
  );

  // Job FSM: accept in IDLE, accumulate one partial product per edge in RUN,
  // publish the result with a one-cycle done pulse; state 2'b11 behaves as IDLE
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state   <= ST_IDLE;
      r_a       <= '0;
      r_b       <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_product <= '0;
    end else begin
      case (r_state)
        ST_RUN: begin
          r_acc <= w_sum;
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == LAST) begin
            r_product <= w_sum;
            r_done    <= 1'b1;
            r_state   <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_RUN;
          end else begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign product = r_product;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// tb/tb_mult_seq_ctrl.sv - self-checking bench for mult_seq_ctrl
module tb_mult_seq_ctrl;

  localparam int W = 5;

  logic           CLOCK_50;
  logic           RESET_N;
  logic           start;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;

  int n_vec;
  int n_err;

  typedef struct {
    logic [W-1:0] va;
    logic [W-1:0] vb;
    int           prod;
  } vec_t;

  vec_t vecs[7];

  mult_seq_ctrl #(.WIDTH(W)) dut (
    .CLOCK_50 (CLOCK_50),
    .RESET_N  (RESET_N),
    .start    (start),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .product  (product)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp_v);
    end
  endtask

  // Issue one job from IDLE and check latency, result, done width and return to idle
  task automatic run_job(input logic [W-1:0] ta, input logic [W-1:0] tbv, input int exp_p,
                         input string nm);
    int lat;
    bit seen;
    @(negedge CLOCK_50);
    a = ta; b = tbv; start = 1'b1;
    @(negedge CLOCK_50);
    start = 1'b0;
    a = W'($urandom); b = W'($urandom);
    check({nm, " busy"}, 32'(busy), 32'd1);
    seen = 1'b0;
    lat  = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge CLOCK_50);
      if (done) begin
        seen = 1'b1;
        lat  = k;
        break;
      end
    end
    check({nm, " done seen"}, 32'(seen), 32'd1);
    if (seen) begin
      check({nm, " latency"}, 32'(lat), 32'(W));
      check({nm, " product"}, 32'(product), 32'(exp_p));
      @(negedge CLOCK_50);
      check({nm, " done width"}, 32'(done), 32'd0);
      check({nm, " idle busy"}, 32'(busy), 32'd0);
    end
  endtask

  initial begin
    int prev_t;
    int low_run;
    int n_done;
    bit any_done;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    n_vec = 0;
    n_err = 0;
    vecs[0] = '{5'd13, 5'd11, 143};
    vecs[1] = '{5'd31, 5'd31, 961};
    vecs[2] = '{5'd0,  5'd31, 0};
    vecs[3] = '{5'd31, 5'd0,  0};
    vecs[4] = '{5'd1,  5'd1,  1};
    vecs[5] = '{5'd16, 5'd17, 272};
    vecs[6] = '{5'd5,  5'd6,  30};

    RESET_N = 1'b0; start = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge CLOCK_50);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset product", 32'(product), 32'd0);
    RESET_N = 1'b1;

    // Directed table
    for (int i = 0; i < 7; i++) begin
      run_job(vecs[i].va, vecs[i].vb, vecs[i].prod, $sformatf("vec%0d", i));
    end

    // start pulsed and operands changed during RUN must not disturb the job
    @(negedge CLOCK_50);
    a = 5'd9; b = 5'd10; start = 1'b1;
    @(negedge CLOCK_50);
    start = 1'b0;
    @(negedge CLOCK_50);
    a = 5'd2; b = 5'd3; start = 1'b1;
    @(negedge CLOCK_50);
    start = 1'b0; a = 5'd31; b = 5'd31;
    any_done = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge CLOCK_50);
      if (done) begin
        any_done = 1'b1;
        break;
      end
    end
    check("midrun done seen", 32'(any_done), 32'd1);
    check("midrun product", 32'(product), 32'd90);
    any_done = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge CLOCK_50);
      if (done || busy) any_done = 1'b1;
    end
    check("midrun second start ignored", 32'(any_done), 32'd0);
    check("midrun product held", 32'(product), 32'd90);

    // start held high: back-to-back jobs every W+2 cycles
    @(negedge CLOCK_50);
    a = 5'd7; b = 5'd9; start = 1'b1;
    prev_t = -1; low_run = 0; n_done = 0;
    for (int t = 0; t < 40; t++) begin
      @(negedge CLOCK_50);
      if (done) begin
        n_done++;
        check("held product", 32'(product), 32'd63);
        if (prev_t >= 0) check("held period", 32'(t - prev_t), 32'(W + 2));
        prev_t = t;
      end
      if (!busy) low_run++;
      else begin
        if (low_run > 0 && n_done > 0) check("held busy gap", 32'(low_run), 32'd1);
        low_run = 0;
      end
    end
    check("held done count", 32'(n_done >= 5), 32'd1);
    start = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge CLOCK_50);
      if (!busy) break;
    end
    check("held drains to idle", 32'(busy), 32'd0);

    // Asynchronous reset mid-RUN aborts the job
    @(negedge CLOCK_50);
    a = 5'd13; b = 5'd11; start = 1'b1;
    @(posedge CLOCK_50);
    #1 start = 1'b0;
    repeat (3) @(posedge CLOCK_50);
    #2 RESET_N = 1'b0;
    #1;
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort product", 32'(product), 32'd0);
    any_done = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge CLOCK_50);
      if (done) any_done = 1'b1;
    end
    check("abort no done", 32'(any_done), 32'd0);
    RESET_N = 1'b1;
    run_job(5'd5, 5'd6, 30, "after reset");

    // Random jobs against the arithmetic model
    for (int i = 0; i < 20; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      run_job(ra, rb, int'(ra) * int'(rb), $sformatf("rand%0d", i));
    end

    // Exhaustive sweep
    for (int ia = 0; ia < 32; ia++) begin
      for (int ib = 0; ib < 32; ib++) begin
        run_job(W'(ia), W'(ib), ia * ib, $sformatf("sweep %0d*%0d", ia, ib));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
